// File: rtl/phase_rotator.sv
// Pipelined complex phase rotator: folds the angle into the first octant, reads cos/sin from an
// external synchronous ROM, restores the octant, multiplies and rescales. Define ROTATE_ROUND_EN for round-half-up.
module phase_rotator #(
    parameter int ROTATE_WIDTH = 9,
    parameter int ROTATE_SCALE = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             phase,
    output logic [ROTATE_WIDTH-1:0] rot_addr,
    input  logic [31:0]             rot_data,
    input  logic                    ivalid,
    input  logic [15:0]             idata_r,
    input  logic [15:0]             idata_i,
    output logic                    ovalid,
    output logic [15:0]             result_r,
    output logic [15:0]             result_i
);

    localparam real PI_R   = 3.14159265358979323846;
    localparam real UNIT   = 2.0 ** ROTATE_WIDTH;
    localparam int  PI     = $rtoi(PI_R * UNIT + 0.5);
    localparam int  PI_2   = $rtoi(PI_R * UNIT / 2.0 + 0.5);
    localparam int  PI_4   = $rtoi(PI_R * UNIT / 4.0 + 0.5);
    localparam int  TWO_PI = 2 * PI;

    localparam logic signed [33:0] SAT_MAX = 34'sd32767;
    localparam logic signed [33:0] SAT_MIN = -34'sd32768;

    // Stage registers
    logic                    v1_q, v2_q, v3_q, v4_q, v5_q;
    logic                    neg1_q, neg2_q, neg3_q;
    logic                    ncos2_q, ncos3_q, swap2_q, swap3_q;
    logic [15:0]             a1_q;
    logic [15:0]             r1_q, r2_q, r3_q, i1_q, i2_q, i3_q;
    logic signed [15:0]      r4_q, i4_q, c4_q, s4_q;
    logic signed [31:0]      rc_q, is_q, rs_q, ic_q;
    logic [ROTATE_WIDTH-1:0] rot_addr_q;
    logic                    ovalid_q;
    logic [15:0]             res_r_q, res_i_q;

    // Next-state values
    logic                    neg1_d, ncos2_d, swap2_d;
    logic [15:0]             a1_d;
    logic [ROTATE_WIDTH-1:0] rot_addr_d;
    logic signed [15:0]      c4_d, s4_d;
    logic [15:0]             res_r_d, res_i_d;

    int                      p_w, a_w, f_w;
    logic signed [33:0]      re_w, im_w;

    function automatic logic [15:0] sat16(input logic signed [33:0] x);
        if (x > SAT_MAX)      return 16'h7fff;
        else if (x < SAT_MIN) return 16'h8000;
        else                  return x[15:0];
    endfunction

    // S1: wrap into [-PI, PI], split sign and magnitude
    always_comb begin
        p_w = int'($signed(phase));
        if (p_w > PI)       p_w = p_w - TWO_PI;
        else if (p_w < -PI) p_w = p_w + TWO_PI;
        neg1_d = (p_w < 0);
        a1_d   = 16'(neg1_d ? -p_w : p_w);
    end

    // S2: fold magnitude into [0, PI_4]; equality cases stay unfolded
    always_comb begin
        a_w     = int'(a1_q);
        ncos2_d = 1'b0;
        f_w     = a_w;
        if (a_w > PI_2) begin
            f_w     = PI - a_w;
            ncos2_d = 1'b1;
        end
        swap2_d    = 1'b0;
        rot_addr_d = ROTATE_WIDTH'(f_w);
        if (f_w > PI_4) begin
            rot_addr_d = ROTATE_WIDTH'(PI_2 - f_w);
            swap2_d    = 1'b1;
        end
    end

    // S4: octant restore from ROM output and delayed flags
    always_comb begin
        c4_d = swap3_q ? $signed(rot_data[15:0])  : $signed(rot_data[31:16]);
        s4_d = swap3_q ? $signed(rot_data[31:16]) : $signed(rot_data[15:0]);
        if (ncos3_q) c4_d = -c4_d;
        if (neg3_q)  s4_d = -s4_d;
    end

    // S6: combine, rescale, saturate
    always_comb begin
        re_w = 34'(rc_q) - 34'(is_q);
        im_w = 34'(rs_q) + 34'(ic_q);
`ifdef ROTATE_ROUND_EN
        re_w = re_w + (34'sd1 <<< (ROTATE_SCALE - 1));
        im_w = im_w + (34'sd1 <<< (ROTATE_SCALE - 1));
`endif
        res_r_d = sat16(re_w >>> ROTATE_SCALE);
        res_i_d = sat16(im_w >>> ROTATE_SCALE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0; v5_q <= 1'b0;
            ovalid_q   <= 1'b0;
            rot_addr_q <= '0;
            res_r_q    <= '0;
            res_i_q    <= '0;
        end else begin
            v1_q <= ivalid; v2_q <= v1_q; v3_q <= v2_q; v4_q <= v3_q; v5_q <= v4_q;
            ovalid_q   <= v5_q;
            rot_addr_q <= rot_addr_d;
            if (v5_q) begin
                res_r_q <= res_r_d;
                res_i_q <= res_i_d;
            end
        end
        neg1_q  <= neg1_d;  a1_q    <= a1_d;
        r1_q    <= idata_r; i1_q    <= idata_i;
        neg2_q  <= neg1_q;  ncos2_q <= ncos2_d; swap2_q <= swap2_d;
        r2_q    <= r1_q;    i2_q    <= i1_q;
        neg3_q  <= neg2_q;  ncos3_q <= ncos2_q; swap3_q <= swap2_q;
        r3_q    <= r2_q;    i3_q    <= i2_q;
        c4_q    <= c4_d;    s4_q    <= s4_d;
        r4_q    <= $signed(r3_q);
        i4_q    <= $signed(i3_q);
        rc_q    <= r4_q * c4_q;
        is_q    <= i4_q * s4_q;
        rs_q    <= r4_q * s4_q;
        ic_q    <= i4_q * c4_q;
    end

    assign rot_addr = rot_addr_q;
    assign ovalid   = ovalid_q;
    assign result_r = res_r_q;
    assign result_i = res_i_q;

endmodule

// File: tb/tb_phase_rotator.sv
// Self-checking bench for phase_rotator: directed table, randomized stream against a reference model,
// mid-stream reset. Honours ROTATE_ROUND_EN like the design.
module tb_phase_rotator;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] phase, idata_r, idata_i;
    logic [8:0]  rot_addr;
    logic [31:0] rot_data;
    logic        ivalid, ovalid;
    logic [15:0] result_r, result_i;

    phase_rotator #(.ROTATE_WIDTH(9), .ROTATE_SCALE(11)) dut (
        .clock(clock), .reset(reset), .phase(phase), .rot_addr(rot_addr), .rot_data(rot_data),
        .ivalid(ivalid), .idata_r(idata_r), .idata_i(idata_i), .ovalid(ovalid),
        .result_r(result_r), .result_i(result_i)
    );

    always #5 clock = ~clock;

    int rom_c [0:511];
    int rom_s [0:511];

    always @(posedge clock) rot_data <= {16'(rom_c[rot_addr]), 16'(rom_s[rot_addr])};

    typedef struct { logic [15:0] r, i; } exp_t;
    typedef struct {
        logic [15:0] ph, r, i;
        logic [8:0]  addr;
        logic        chk;
        logic [15:0] er, ei;
    } vec_t;

    exp_t        q[$];
    logic [5:0]  hist = '0;
    logic [15:0] last_r = '0, last_i = '0;
    logic        rst_chk = 1'b0;
    int          addr_cnt = 0;
    logic [8:0]  addr_exp = '0;
    int          total = 0, bad = 0;

    function automatic logic [15:0] sat(input longint x);
        if (x > 32767)       return 16'h7fff;
        else if (x < -32768) return 16'h8000;
        else                 return 16'(x);
    endfunction

    // Rotation by the quantized ROM angle, using first-quadrant symmetry of cos/sin
    function automatic logic [31:0] model(input int ph, input int r, input int i);
        int p, a, m, c, s;
        longint re, im;
        p = ph;
        if (p > 1608)       p -= 3216;
        else if (p < -1608) p += 3216;
        a = (p < 0) ? -p : p;
        m = (a > 804) ? 1608 - a : a;
        if (m > 402) begin c = rom_s[804 - m]; s = rom_c[804 - m]; end
        else         begin c = rom_c[m];       s = rom_s[m];       end
        if (a > 804) c = -c;
        if (p < 0)   s = -s;
        re = longint'(r) * c - longint'(i) * s;
        im = longint'(r) * s + longint'(i) * c;
`ifdef ROTATE_ROUND_EN
        re += 1024;
        im += 1024;
`endif
        re = re >>> 11;
        im = im >>> 11;
        return {sat(re), sat(im)};
    endfunction

    task automatic tick(input logic rst, input logic v, input logic [15:0] ph, dr, di,
                        input logic use_exp, input logic [15:0] er, ei,
                        input logic chk_addr, input logic [8:0] ea);
        exp_t        e;
        logic [31:0] m;
        @(negedge clock);
        total++;
        if (ovalid !== hist[5]) begin
            bad++;
            $display("FAIL ovalid got=%0b exp=%0b t=%0t", ovalid, hist[5], $time);
        end
        if (hist[5] && q.size() > 0) begin
            e = q.pop_front();
            last_r = e.r;
            last_i = e.i;
        end
        total++;
        if (result_r !== last_r || result_i !== last_i) begin
            bad++;
            $display("FAIL result got=(%0d,%0d) exp=(%0d,%0d) t=%0t", $signed(result_r),
                     $signed(result_i), $signed(last_r), $signed(last_i), $time);
        end
        if (rst_chk) begin
            total++;
            if (rot_addr !== 9'd0) begin
                bad++;
                $display("FAIL rot_addr_reset got=%0d exp=0", rot_addr);
            end
        end
        if (addr_cnt == 1) begin
            total++;
            if (rot_addr !== addr_exp) begin
                bad++;
                $display("FAIL rot_addr got=%0d exp=%0d t=%0t", rot_addr, addr_exp, $time);
            end
        end
        if (addr_cnt > 0) addr_cnt--;

        reset = rst; ivalid = v; phase = ph; idata_r = dr; idata_i = di;
        if (rst) begin
            hist = '0; q.delete(); last_r = '0; last_i = '0; rst_chk = 1'b1;
        end else begin
            rst_chk = 1'b0;
            hist = {hist[4:0], v};
            if (v) begin
                m = model(int'($signed(ph)), int'($signed(dr)), int'($signed(di)));
                e.r = use_exp ? er : m[31:16];
                e.i = use_exp ? ei : m[15:0];
                q.push_back(e);
            end
        end
        if (chk_addr) begin addr_cnt = 2; addr_exp = ea; end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic rand_run(input int n);
        logic [15:0] edges [12];
        logic [15:0] ph;
        edges = '{16'(3216), 16'(-3216), 16'(1608), 16'(-1608), 16'(1609), 16'(-1609),
                  16'(804), 16'(805), 16'(-804), 16'(402), 16'(403), 16'(0)};
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(7) == 0) ph = edges[$urandom_range(11)];
            else                        ph = 16'(int'($urandom_range(6432)) - 3216);
            tick(1'b0, $urandom_range(3) != 0, ph, 16'($urandom), 16'($urandom),
                 1'b0, '0, '0, 1'b0, '0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        for (int k = 0; k < 512; k++) begin
            rom_c[k] = $rtoi($cos(real'(k) / 512.0) * 2048.0 + 0.5);
            rom_s[k] = $rtoi($sin(real'(k) / 512.0) * 2048.0 + 0.5);
        end
        vecs[0] = '{16'(0),    16'(1000),   16'(-500),   9'd0,   1'b1, 16'(1000),  16'(-500)};
        vecs[1] = '{16'(804),  16'(1000),   16'(0),      9'd0,   1'b1, 16'(0),     16'(1000)};
        vecs[2] = '{16'(-804), 16'(1000),   16'(0),      9'd0,   1'b1, 16'(0),     16'(-1000)};
        vecs[3] = '{16'(1608), 16'(1000),   16'(0),      9'd0,   1'b1, 16'(-1000), 16'(0)};
        vecs[4] = '{16'(1206), 16'(1000),   16'(300),    9'd402, 1'b0, 16'(0),     16'(0)};
        vecs[5] = '{16'(2000), 16'(-700),   16'(1200),   9'd392, 1'b0, 16'(0),     16'(0)};
        vecs[6] = '{16'(1608), 16'(-32768), 16'(-32768), 9'd0,   1'b1, 16'(32767), 16'(32767)};

        reset = 1'b1; ivalid = 1'b0; phase = '0; idata_r = '0; idata_i = '0;
        rst_chk = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        idle(4);

        foreach (vecs[k]) begin
            tick(1'b0, 1'b1, vecs[k].ph, vecs[k].r, vecs[k].i, vecs[k].chk, vecs[k].er,
                 vecs[k].ei, 1'b1, vecs[k].addr);
            idle(2);
        end
        idle(8);

        rand_run(400);

        // Reset in the middle of a busy stream, then confirm nothing stale emerges
        tick(1'b1, 1'b1, 16'(100), 16'(1234), 16'(-4321), 1'b0, '0, '0, 1'b0, '0);
        idle(10);

        rand_run(150);
        idle(8);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
